// File: rtl/acc_uart_tx.sv
// UART transmitter for the accumulator output path: start bit, 8 data bits LSB first,
// optional even-parity bit, stop bit. All outputs are registered.
module acc_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter bit          PARITY_EN    = 1'b0
) (
    input  logic       clk,
    input  logic       nReset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int unsigned   CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t        state_q;
    logic [CW-1:0] baud_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic          par_q;
    logic          tx_q;
    logic          busy_q;
    logic          done_q;
    logic          bit_end_s;

    // Even parity: the extra bit makes the total count of ones even.
    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

    assign bit_end_s = (baud_q == BAUD_LAST);

    // Frame sequencer: tx is loaded one bit ahead so it changes exactly on bit boundaries.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                    if (start) begin
                        shift_q <= data;
                        par_q   <= even_parity(data);
                        baud_q  <= '0;
                        bit_q   <= 3'd0;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_START;
                    end
                end
                S_START: begin
                    if (bit_end_s) begin
                        baud_q  <= '0;
                        bit_q   <= 3'd0;
                        tx_q    <= shift_q[0];
                        state_q <= S_DATA;
                    end else begin
                        baud_q <= baud_q + CW'(1);
                    end
                end
                S_DATA: begin
                    if (bit_end_s) begin
                        baud_q  <= '0;
                        shift_q <= {1'b0, shift_q[7:1]};
                        if (bit_q == 3'd7) begin
                            bit_q <= 3'd0;
                            if (PARITY_EN) begin
                                tx_q    <= par_q;
                                state_q <= S_PARITY;
                            end else begin
                                tx_q    <= 1'b1;
                                state_q <= S_STOP;
                            end
                        end else begin
                            bit_q <= bit_q + 3'd1;
                            tx_q  <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + CW'(1);
                    end
                end
                S_PARITY: begin
                    if (bit_end_s) begin
                        baud_q  <= '0;
                        tx_q    <= 1'b1;
                        state_q <= S_STOP;
                    end else begin
                        baud_q <= baud_q + CW'(1);
                    end
                end
                S_STOP: begin
                    if (bit_end_s) begin
                        baud_q  <= '0;
                        tx_q    <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        baud_q <= baud_q + CW'(1);
                    end
                end
                default: begin
                    baud_q  <= '0;
                    bit_q   <= 3'd0;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_acc_uart_tx.sv
// Bench for acc_uart_tx: one instance without parity, one with, both at 4 clocks per bit,
// compared cycle by cycle against a frame built from the byte with plain arithmetic.
module tb_acc_uart_tx;

    localparam int C = 4;

    logic       clk = 1'b0;
    logic       nReset;
    logic       start_n, start_p;
    logic [7:0] data_n, data_p;
    logic       tx_n, busy_n, done_n;
    logic       tx_p, busy_p, done_p;
    int         passes = 0;
    int         total  = 0;

    acc_uart_tx #(.CLKS_PER_BIT(C), .PARITY_EN(1'b0)) dut_n (
        .clk(clk), .nReset(nReset), .start(start_n), .data(data_n),
        .tx(tx_n), .busy(busy_n), .done(done_n)
    );

    acc_uart_tx #(.CLKS_PER_BIT(C), .PARITY_EN(1'b1)) dut_p (
        .clk(clk), .nReset(nReset), .start(start_p), .data(data_p),
        .tx(tx_p), .busy(busy_p), .done(done_p)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
    endtask

    task automatic drive(input bit p, input logic s, input logic [7:0] d);
        if (p) begin
            start_p = s;
            data_p  = d;
        end else begin
            start_n = s;
            data_n  = d;
        end
    endtask

    task automatic check_outs(input bit p, input string tag, input logic etx, input logic ebusy,
                              input logic edone);
        check({tag, " tx"},   p ? tx_p   : tx_n,   etx);
        check({tag, " busy"}, p ? busy_p : busy_n, ebusy);
        check({tag, " done"}, p ? done_p : done_n, edone);
    endtask

    // Sends one byte starting at the current negedge and checks every cycle of the frame.
    // hold keeps start high (next byte 0x55) for a back-to-back follow-up; inject pulses a
    // stray start with 0xFF at cycle 10; abort_at >= 0 pulls reset at that cycle.
    task automatic run_frame(input bit p, input logic [7:0] d, input bit hold, input bit inject,
                             input int abort_at);
        logic [10:0] fb;
        int          ones;
        int          nbits;
        bit          aborted;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        nbits    = p ? 11 : 10;
        fb       = '1;
        fb[0]    = 1'b0;
        fb[8:1]  = d;
        if (p) fb[9] = (ones % 2 == 1);
        aborted = 1'b0;
        drive(p, 1'b1, d);
        @(posedge clk);
        for (int t = 0; t < nbits * C; t++) begin
            @(negedge clk);
            if (t == abort_at) begin
                #2 nReset = 1'b0;
                #1 check_outs(p, "async reset", 1'b1, 1'b0, 1'b0);
                drive(p, 1'b0, 8'h00);
                repeat (3) @(negedge clk);
                nReset = 1'b1;
                repeat (C * 4) begin
                    @(negedge clk);
                    check_outs(p, "after abort", 1'b1, 1'b0, 1'b0);
                end
                aborted = 1'b1;
                break;
            end
            check_outs(p, "frame", fb[t / C], 1'b1, 1'b0);
            if (t == 0) drive(p, hold, hold ? 8'h55 : ~d);
            if (inject && t == 10) drive(p, 1'b1, 8'hFF);
            if (inject && t == 11) drive(p, 1'b0, 8'hFF);
        end
        if (!aborted) begin
            @(negedge clk);
            check_outs(p, "done cycle", 1'b1, 1'b0, 1'b1);
            if (!hold) begin
                @(negedge clk);
                check_outs(p, "post idle", 1'b1, 1'b0, 1'b0);
            end
        end
    endtask

    initial begin
        bit         rp;
        logic [7:0] rd;
        nReset  = 1'b0;
        start_n = 1'b0;
        start_p = 1'b0;
        data_n  = 8'h00;
        data_p  = 8'h00;
        repeat (2) @(negedge clk);
        check_outs(1'b0, "reset n", 1'b1, 1'b0, 1'b0);
        check_outs(1'b1, "reset p", 1'b1, 1'b0, 1'b0);
        nReset = 1'b1;
        @(negedge clk);

        run_frame(1'b0, 8'hA5, 1'b0, 1'b1, -1);
        run_frame(1'b1, 8'h07, 1'b0, 1'b0, -1);
        run_frame(1'b1, 8'h03, 1'b0, 1'b0, -1);

        run_frame(1'b0, 8'hA5, 1'b1, 1'b0, -1);
        run_frame(1'b0, 8'h55, 1'b0, 1'b0, -1);
        run_frame(1'b1, 8'h81, 1'b1, 1'b0, -1);
        run_frame(1'b1, 8'h55, 1'b0, 1'b0, -1);

        run_frame(1'b0, 8'hC3, 1'b0, 1'b0, 20);
        run_frame(1'b0, 8'h3C, 1'b0, 1'b0, -1);
        run_frame(1'b1, 8'hE1, 1'b0, 1'b0, 25);
        run_frame(1'b1, 8'h3C, 1'b0, 1'b0, -1);

        for (int k = 0; k < 8; k++) begin
            rp = 1'($urandom_range(0, 1));
            rd = 8'($urandom_range(0, 255));
            run_frame(rp, rd, 1'b0, 1'b0, -1);
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/acc_uart_tx.md
# acc_uart_tx

Serial transmitter for the accumulator output path: on a one-cycle `start` strobe it captures an 8-bit value, normally the accumulator output, and shifts it out as an asynchronous UART frame. The frame is start bit, 8 data bits LSB first, an optional even-parity bit, and a stop bit. It is the output-side counterpart to the accumulator and carry registers, driven by the core's OUT operation and reporting `busy`/`done` back to the control logic.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; legal range 2..65535.
- `PARITY_EN`, 0: 1 inserts an even-parity bit between data bit 7 and the stop bit; 0 omits it.

- `clk`  input  1  system clock; all state updates on rising edge.
- `nReset`  input  1  reset, asynchronous, active-low.
- `start`  input  1  request to transmit `data`; sampled on rising edge.
- `data`  input  8  byte to transmit (accumulator value); sampled only on the accepting edge.
- `tx`  output  1  serial line, idle high.
- `busy`  output  1  high while a frame is in progress.
- `done`  output  1  one-cycle pulse at frame completion.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Counters:
  - Baud counter counts 0..CLKS_PER_BIT-1.
  - Bit index counts 0..7.
  - Shift register holds 8 bits; parity accumulator is 1 bit.
- **IDLE:** `tx`=1, `busy`=0. If `start`=1 on an edge, latch `data` into the shift register, compute parity = XOR of the `data` bits, clear the baud counter, and go to START.
- **START:** `tx`=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- **DATA:**
  - `tx`=shift[0] for CLKS_PER_BIT cycles, then shift right.
  - After bit 7, go to PARITY if `PARITY_EN`=1, else to STOP.
- **PARITY:** `tx`=parity bit, so total ones in data+parity is even, held for CLKS_PER_BIT cycles; then go to STOP.
- **STOP:** `tx`=1 for CLKS_PER_BIT cycles, then go to IDLE and assert `done` for exactly one cycle.
- `start` while not in IDLE is ignored; no queuing. Changes on `data` after acceptance have no effect on the frame in flight.
- `start` asserted in the cycle `done` is high is accepted: the back-to-back frame begins with no extra idle cycle.
- `tx`, `busy` and `done` are registered outputs; there is no combinational path from inputs to outputs.

## Timing
- Reset values, applied immediately on `nReset` falling, independent of `clk`:
  - `tx`=1, `busy`=0, `done`=0.
  - State IDLE; all counters 0; shift register 0x00.
- Reset mid-frame aborts the frame: `tx` returns to 1 without completing the stop bit, and `done` is not pulsed.
- After `nReset` deasserts, the first `start` edge is accepted normally.
- Acceptance edge E: `tx` falls and `busy` rises in the cycle following E. This is 1-cycle latency from `start` to the line.
- Frame length N = (10 + PARITY_EN) × CLKS_PER_BIT cycles.
  - `busy` is high for exactly N cycles.
  - `done` is high for 1 cycle immediately after, with `busy`=0 in that cycle.
- Bit k of the frame (0 = start) occupies cycles E+1+k×CLKS_PER_BIT .. E+(k+1)×CLKS_PER_BIT.
- Baud counter wraps from CLKS_PER_BIT-1 to 0 on each bit boundary; there is no drift across the frame.

## Test plan
- **Reset:** assert `nReset`=0 asynchronously mid-cycle -> `tx`=1, `busy`=0, `done`=0 before the next clock edge.
- **Single frame:** `CLKS_PER_BIT`=4, `PARITY_EN`=0, `data`=0xA5, one-cycle `start`.
  - Line, sampled at bit centers: 0,1,0,1,0,0,1,0,1,1.
  - `busy` high 40 cycles, then `done` high 1 cycle.
- **Parity:** `PARITY_EN`=1, `data`=0x07 -> parity bit 1, frame 44 cycles.
  - Repeat with `data`=0x03 -> parity bit 0.
- **Ignored start and data change:** during the 0xA5 frame, pulse `start` with `data`=0xFF at cycle 10 -> the frame is unchanged and no second frame follows.
- **Back-to-back:** hold `start`=1 with `data`=0x55 through `done` -> the second frame's start bit begins the cycle after `done`, with no idle-high gap.
- **Abort:** pull `nReset` low at cycle 20 of a frame, release, then send 0x3C -> the aborted frame produces no `done`, and 0x3C is transmitted correctly.
